gru_ht_update: RTL and testbench

Final-stage GRU hidden-state updater that consumes the per-cell candidate state h~t produced by the candidate-hidden-state datapath. It computes ht = ht1 + zt⊙(h~t − ht1) cell by cell, collects CELLNUM results into the packed hidden vector, and feeds that vector back as ht1 for the next timestep. It sequences STEP timesteps and handshakes the candidate datapath through a step request pulse.

---
 rtl/gru_ht_if.sv | 31 +++
 rtl/gru_ht_update.sv | 145 ++++++++++++++
 tb/tb_gru_ht_update.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gru_ht_if.sv
// Handshake bundle between the candidate-state datapath and the GRU hidden-state updater.
// The slave modport is the updater side; the master modport is the upstream/driver side.
interface gru_ht_if #(
  parameter int CELLNUM = 4,
  parameter int DATABIT = 16,
  parameter int IDXBIT  = 2
);
  logic                       start;
  logic [CELLNUM*DATABIT-1:0] h0;
  logic [CELLNUM*DATABIT-1:0] zt;
  logic                       cand_valid;
  logic [IDXBIT-1:0]          cand_idx;
  logic [DATABIT-1:0]         cand;
  logic [CELLNUM*DATABIT-1:0] ht1_out;
  logic                       step_req;
  logic                       busy;
  logic                       ht_valid;
  logic [CELLNUM*DATABIT-1:0] ht_out;
  logic [3:0]                 step_cnt;
  logic                       done;

  modport master (
    output start, h0, zt, cand_valid, cand_idx, cand,
    input  ht1_out, step_req, busy, ht_valid, ht_out, step_cnt, done
  );

  modport slave (
    input  start, h0, zt, cand_valid, cand_idx, cand,
    output ht1_out, step_req, busy, ht_valid, ht_out, step_cnt, done
  );
endinterface

// File: rtl/gru_ht_update.sv
// GRU hidden-state updater: ht = ht1 + zt*(h~t - ht1) per cell, two-stage pipe, commits the full vector per step.
// Define GRU_HT_SAT_EN to clamp the per-cell result; otherwise it wraps to DATABIT bits.
module gru_ht_update #(
  parameter int CELLNUM = 4,
  parameter int DATABIT = 16,
  parameter int FRACBIT = 8,
  parameter int STEP    = 10,
  parameter int IDXBIT  = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  gru_ht_if.slave bus
);
  localparam int PW = 2*DATABIT+1;
  localparam logic signed [PW-1:0] MAXV = {{(PW-DATABIT+1){1'b0}}, {(DATABIT-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-DATABIT+1){1'b1}}, {(DATABIT-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;
  typedef logic [CELLNUM-1:0][DATABIT-1:0] vec_t;

  state_t state, state_nxt;

  vec_t               ht1_q, ht_q, hnew, zt_a;
  logic [CELLNUM-1:0] mask;
  logic               mask_full, last_step, idx_ok, accept;
  logic [3:0]         step_cnt;
  logic               step_req, ht_valid, done;

  // stage-1 pipeline registers
  logic                      s1_vld;
  logic signed [DATABIT:0]   s1_diff;
  logic signed [DATABIT-1:0] s1_z;
  logic [IDXBIT-1:0]         s1_idx;

  logic signed [DATABIT-1:0] cand_s, ht1_sel, ht1_s2;
  logic signed [DATABIT:0]   diff_c;
  logic signed [PW-1:0]      prod, sum;
  logic [DATABIT-1:0]        res;

  assign zt_a      = bus.zt;
  assign mask_full = &mask;
  assign last_step = (step_cnt == 4'(STEP-1));
  assign idx_ok    = (32'(bus.cand_idx) < CELLNUM);
  // once every cell is in, further candidates would only race the commit
  assign accept    = (state == WAIT) && bus.cand_valid && idx_ok && !mask_full;

  // stage 1: difference against the current hidden state
  assign cand_s  = bus.cand;
  assign ht1_sel = ht1_q[bus.cand_idx];
  assign diff_c  = (DATABIT+1)'(cand_s) - (DATABIT+1)'(ht1_sel);

  // stage 2: scale by gate, rescale, add back ht1
  assign ht1_s2 = ht1_q[s1_idx];
  assign prod   = PW'(s1_diff) * PW'(s1_z);
  assign sum    = (prod >>> FRACBIT) + PW'(ht1_s2);

`ifdef GRU_HT_SAT_EN
  always_comb begin
    res = sum[DATABIT-1:0];
    if (sum > MAXV)      res = MAXV[DATABIT-1:0];
    else if (sum < MINV) res = MINV[DATABIT-1:0];
  end
`else
  logic sum_unused;
  assign sum_unused = ^{sum[PW-1:DATABIT], MAXV, MINV};
  assign res        = sum[DATABIT-1:0];
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (bus.start) state_nxt = WAIT;
    else begin
      case (state)
        WAIT:    if (mask_full) state_nxt = COMMIT;
        COMMIT:  state_nxt = last_step ? IDLE : WAIT;
        default: state_nxt = state;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    bus.busy = (state == WAIT) || (state == COMMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ht1_q    <= '0;
      ht_q     <= '0;
      hnew     <= '0;
      mask     <= '0;
      step_cnt <= '0;
      step_req <= 1'b0;
      ht_valid <= 1'b0;
      done     <= 1'b0;
      s1_vld   <= 1'b0;
      s1_diff  <= '0;
      s1_z     <= '0;
      s1_idx   <= '0;
    end else begin
      step_req <= 1'b0;
      ht_valid <= 1'b0;
      done     <= 1'b0;
      if (bus.start) begin
        ht1_q    <= bus.h0;
        mask     <= '0;
        step_cnt <= '0;
        s1_vld   <= 1'b0;
        step_req <= 1'b1;
      end else begin
        s1_vld  <= accept;
        s1_diff <= diff_c;
        s1_z    <= zt_a[bus.cand_idx];
        s1_idx  <= bus.cand_idx;
        if (state == WAIT && s1_vld && !mask_full) begin
          hnew[s1_idx] <= res;
          mask[s1_idx] <= 1'b1;
        end
        if (state == COMMIT) begin
          ht1_q    <= hnew;
          ht_q     <= hnew;
          ht_valid <= 1'b1;
          step_cnt <= step_cnt + 4'd1;
          mask     <= '0;
          s1_vld   <= 1'b0;
          if (last_step) done     <= 1'b1;
          else           step_req <= 1'b1;
        end
      end
    end
  end

  assign bus.ht1_out  = ht1_q;
  assign bus.ht_out   = ht_q;
  assign bus.step_cnt = step_cnt;
  assign bus.step_req = step_req;
  assign bus.ht_valid = ht_valid;
  assign bus.done     = done;
endmodule

// File: tb/tb_gru_ht_update.sv
// Directed + randomized bench for gru_ht_update against a per-cell arithmetic model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_gru_ht_update;
  localparam int CELLNUM = 4;
  localparam int DATABIT = 16;
  localparam int FRACBIT = 8;
  localparam int STEP    = 10;
  localparam int IDXBIT  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gru_ht_if #(.CELLNUM(CELLNUM), .DATABIT(DATABIT), .IDXBIT(IDXBIT)) bus ();

  gru_ht_update #(.CELLNUM(CELLNUM), .DATABIT(DATABIT), .FRACBIT(FRACBIT),
                  .STEP(STEP), .IDXBIT(IDXBIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // pulse counters, sampled just before each rising edge
  int n_hv = 0, n_sr = 0, n_done = 0;
  always @(posedge clk) begin
    if (bus.ht_valid) n_hv   <= n_hv + 1;
    if (bus.step_req) n_sr   <= n_sr + 1;
    if (bus.done)     n_done <= n_done + 1;
  end

  // model state
  logic [15:0] mh1  [CELLNUM];
  logic [15:0] mz   [CELLNUM];
  logic [15:0] mnew [CELLNUM];
  int          ord  [CELLNUM];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ht = ht1 + floor((c - ht1) * z / 2^FRACBIT), then clamp or wrap
  function automatic logic [15:0] ref_cell(logic signed [15:0] h1, logic signed [15:0] z,
                                           logic signed [15:0] c);
    longint p, q, r;
    p = (longint'(c) - longint'(h1)) * longint'(z);
    q = p / (longint'(1) << FRACBIT);
    if (p < 0 && (p % (longint'(1) << FRACBIT)) != 0) q = q - 1;
    r = q + longint'(h1);
`ifdef GRU_HT_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  function automatic logic [63:0] pack(input logic [15:0] v [CELLNUM]);
    logic [63:0] e;
    for (int i = 0; i < CELLNUM; i++) e[i*16 +: 16] = v[i];
    return e;
  endfunction

  task automatic set_zt_all(logic [15:0] z);
    for (int i = 0; i < CELLNUM; i++) mz[i] = z;
    bus.zt = pack(mz);
  endtask

  task automatic do_start(logic [15:0] h);
    for (int i = 0; i < CELLNUM; i++) mh1[i] = h;
    bus.h0 = pack(mh1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start step_req", 64'(bus.step_req), 64'd1);
    chk("start busy", 64'(bus.busy), 64'd1);
    chk("start ht1_out", bus.ht1_out, pack(mh1));
  endtask

  task automatic drive_cell(int idx, logic [15:0] v);
    bus.cand_valid = 1'b1;
    bus.cand_idx   = IDXBIT'(idx);
    bus.cand       = v;
    mnew[idx]      = ref_cell(mh1[idx], mz[idx], v);
    @(negedge clk);
  endtask

  task automatic check_commit(string tag, int exp_cnt, bit last);
    int lat = 1;
    bus.cand_valid = 1'b0;
    while (!bus.ht_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    // 4 falling edges after the last drive = 3 cycles after its sampling edge
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " ht_out"}, bus.ht_out, pack(mnew));
    chk({tag, " ht1_out"}, bus.ht1_out, pack(mnew));
    chk({tag, " step_cnt"}, 64'(bus.step_cnt), 64'(exp_cnt));
    chk({tag, " step_req"}, 64'(bus.step_req), 64'(!last));
    chk({tag, " done"}, 64'(bus.done), 64'(last));
    for (int i = 0; i < CELLNUM; i++) mh1[i] = mnew[i];
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hv0, sr0, dn0;
    bus.start = 1'b0; bus.h0 = '0; bus.zt = '0;
    bus.cand_valid = 1'b0; bus.cand_idx = '0; bus.cand = '0;
    repeat (3) @(negedge clk);

    chk("reset ht1_out", bus.ht1_out, 64'd0);
    chk("reset ht_out", bus.ht_out, 64'd0);
    chk("reset step_cnt", 64'(bus.step_cnt), 64'd0);
    chk("reset pulses", {61'd0, bus.step_req, bus.ht_valid, bus.done}, 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    hv0 = n_hv; sr0 = n_sr; dn0 = n_done;

    // step 1: half-way blend toward zero
    set_zt_all(16'h0080);
    do_start(16'h0100);
    for (int i = 0; i < CELLNUM; i++) drive_cell(i, 16'h0000);
    check_commit("blend", 1, 1'b0);
    chk("blend const", bus.ht_out, {4{16'h0080}});

    // step 2: full gate, out-of-order delivery
    set_zt_all(16'h0100);
    ord = '{3, 1, 0, 2};
    for (int i = 0; i < CELLNUM; i++) drive_cell(ord[i], 16'hFF00);
    check_commit("order", 2, 1'b0);
    chk("order const", bus.ht_out, {4{16'hFF00}});

    // step 3: duplicate index overwrites, no early commit
    drive_cell(1, 16'h0000);
    drive_cell(1, 16'h0100);
    bus.cand_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("dup no early commit", 64'(n_hv - hv0), 64'd2);
    chk("dup busy", 64'(bus.busy), 64'd1);
    drive_cell(0, 16'(($urandom % 65536)));
    drive_cell(2, 16'(($urandom % 65536)));
    drive_cell(3, 16'(($urandom % 65536)));
    check_commit("dup", 3, 1'b0);
    chk("dup cell1", 64'(bus.ht_out[31:16]), 64'h0100);

    // steps 4..STEP: random gates, values and orders
    for (int s = 4; s <= STEP; s++) begin
      for (int i = 0; i < CELLNUM; i++) begin
        mz[i]  = 16'($urandom % 65536);
        ord[i] = i;
      end
      bus.zt = pack(mz);
      for (int i = CELLNUM-1; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(0, i));
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int i = 0; i < CELLNUM; i++) drive_cell(ord[i], 16'($urandom % 65536));
      check_commit($sformatf("rand%0d", s), s, s == STEP);
    end
    chk("seq busy after done", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge clk);
    chk("seq ht_valid count", 64'(n_hv - hv0), 64'(STEP));
    // one pulse from start plus one per non-final commit
    chk("seq step_req count", 64'(n_sr - sr0), 64'(STEP));
    chk("seq done count", 64'(n_done - dn0), 64'd1);

    // saturation / wrap corner
    set_zt_all(16'h0200);
    do_start(16'h7F00);
    for (int i = 0; i < CELLNUM; i++) drive_cell(i, 16'h8000);
    check_commit("sat", 1, 1'b0);
`ifdef GRU_HT_SAT_EN
    chk("sat const", bus.ht_out, {4{16'h8000}});
`else
    chk("wrap const", bus.ht_out, {4{16'h8100}});
`endif

    // async reset mid-step
    set_zt_all(16'h0100);
    do_start(16'h0040);
    drive_cell(0, 16'h1234);
    drive_cell(1, 16'h2345);
    bus.cand_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("areset ht1_out", bus.ht1_out, 64'd0);
    chk("areset ht_out", bus.ht_out, 64'd0);
    chk("areset step_cnt", 64'(bus.step_cnt), 64'd0);
    chk("areset flags", {60'd0, bus.step_req, bus.ht_valid, bus.done, bus.busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hv0 = n_hv; sr0 = n_sr;
    for (int i = 0; i < CELLNUM; i++) drive_cell(i, 16'h0100);
    bus.cand_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle ht_valid count", 64'(n_hv - hv0), 64'd0);
    chk("idle step_req count", 64'(n_sr - sr0), 64'd0);
    chk("idle busy", 64'(bus.busy), 64'd0);
    chk("idle ht_out", bus.ht_out, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
